// File: rtl/dram_resp_pkg.sv
// Shared encodings, AXI struct defaults, FSM states and burst address arithmetic
// for the DRAM AXI responder.
package dram_resp_pkg;

  localparam int unsigned AXI_ID_W   = 8;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_USER_W = 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE  = 2'd0;
  localparam r_state_t R_ISSUE = 2'd1;
  localparam r_state_t R_DATA  = 2'd2;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     aw_id;
    logic [AXI_ADDR_W-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_valid;
    logic [AXI_DATA_W-1:0]   w_data;
    logic [AXI_DATA_W/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    b_ready;
    logic [AXI_ID_W-1:0]     ar_id;
    logic [AXI_ADDR_W-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_valid;
    logic                    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [AXI_USER_W-1:0] b_user;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [AXI_USER_W-1:0] r_user;
    logic                  r_valid;
  } axi_rsp_t;

  typedef struct packed {
    w_state_t w_state;
    r_state_t r_state;
    logic     arb_to_write;
    logic     stall;
  } dram_resp_dbg_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Byte address of the beat following addr; reserved bursts step like INCR
  // because every beat of such a burst is suppressed anyway.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] incr;
    logic [63:0] bound;
    logic [63:0] base;
    step  = 64'd1 << size;
    incr  = (addr & ~(step - 64'd1)) + step;
    bound = (64'(len) + 64'd1) << size;
    base  = addr & ~(bound - 64'd1);
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (incr >= base + bound) ? base : incr;
      default:     return incr;
    endcase
  endfunction

endpackage

// File: rtl/dram_resp_addr_gen.sv
// Combinational next-beat address plus per-beat error flag (bad burst shape,
// oversize beat, or address beyond the memory).
module dram_resp_addr_gen
  import dram_resp_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MemWords  = 2**20
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [2:0]           size_i,
  input  logic [7:0]           len_i,
  input  logic [1:0]           burst_i,
  output logic [AddrWidth-1:0] next_addr_o,
  output logic                 beat_err_o
);

  localparam logic [63:0]  LimitBytes = 64'(MemWords) * 64'(DataWidth / 8);
  localparam int unsigned  MaxSize    = $clog2(DataWidth / 8);

  logic burst_err;
  logic out_of_range;

  assign burst_err = (burst_i == BURST_RSVD) ||
                     (32'(size_i) > MaxSize) ||
                     ((burst_i == BURST_WRAP) && !wrap_len_ok(len_i));

  assign out_of_range = 64'(addr_i) >= LimitBytes;
  assign beat_err_o   = burst_err || out_of_range;
  assign next_addr_o  = AddrWidth'(next_addr(64'(addr_i), size_i, len_i, burst_i));

endmodule

// File: rtl/dram_axi_responder.sv
// AXI4 subordinate serving bursts from a single-port word memory (1-cycle read).
// Optional build macro DRAM_RESP_STALL_EN inserts LFSR-driven backpressure.
module dram_axi_responder
  import dram_resp_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MemWords  = 2**20,
  parameter type         axi_req_t = dram_resp_pkg::axi_req_t,
  parameter type         axi_rsp_t = dram_resp_pkg::axi_rsp_t,
  parameter logic [15:0] StallSeed = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  axi_req_t                     axi_req_i,
  output axi_rsp_t                     axi_rsp_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MemWords)-1:0]  mem_addr_o,
  output logic [DataWidth-1:0]         mem_wdata_o,
  output logic [DataWidth/8-1:0]       mem_be_o,
  input  logic [DataWidth-1:0]         mem_rdata_i,
  output dram_resp_dbg_t               dbg_o
);

  localparam int unsigned OffW  = $clog2(DataWidth / 8);
  localparam int unsigned MemAw = $clog2(MemWords);

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; valid and payload hold until then. ready may depend on valid.

  logic                 ready_en;
  logic                 stall;

  w_state_t             w_state;
  logic [AXI_ID_W-1:0]  w_id;
  logic [AddrWidth-1:0] w_addr;
  logic [AddrWidth-1:0] w_next;
  logic [7:0]           w_len;
  logic [7:0]           w_beat;
  logic [2:0]           w_size;
  logic [1:0]           w_burst;
  logic                 w_err;
  logic                 w_beat_err;

  r_state_t             r_state;
  logic [AXI_ID_W-1:0]  r_id;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth-1:0] r_next;
  logic [7:0]           r_len;
  logic [7:0]           r_beat;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic                 r_beat_err;
  logic                 r_err_q;
  logic                 r_valid_q;
  logic [DataWidth-1:0] r_data_q;

  logic aw_ready;
  logic ar_ready;
  logic w_want;
  logic r_want;
  logic w_gnt;
  logic r_gnt;
  logic w_do;
  logic r_do;
  logic arb_to_write;
  axi_rsp_t rsp;

`ifdef DRAM_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= StallSeed;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[0];
`else
  logic unused_stall_seed;
  assign unused_stall_seed = ^StallSeed;
  assign stall             = 1'b0;
`endif

  // Readys stay low through reset and for the first cycle after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign aw_ready = ready_en && !stall && (w_state == W_IDLE);
  assign ar_ready = ready_en && !stall && (r_state == R_IDLE);

  dram_resp_addr_gen #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .MemWords  (MemWords)
  ) u_w_addr_gen (
    .addr_i      (w_addr),
    .size_i      (w_size),
    .len_i       (w_len),
    .burst_i     (w_burst),
    .next_addr_o (w_next),
    .beat_err_o  (w_beat_err)
  );

  dram_resp_addr_gen #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .MemWords  (MemWords)
  ) u_r_addr_gen (
    .addr_i      (r_addr),
    .size_i      (r_size),
    .len_i       (r_len),
    .burst_i     (r_burst),
    .next_addr_o (r_next),
    .beat_err_o  (r_beat_err)
  );

  // The write side only asks for the port when a beat is actually offered,
  // so an idle W channel never steals a grant from reads.
  assign w_want = (w_state == W_DATA) && axi_req_i.w_valid && !stall;
  assign r_want = (r_state == R_ISSUE) && !stall;

  always_comb begin
    w_gnt = w_want && (!r_want || arb_to_write);
    r_gnt = r_want && (!w_want || !arb_to_write);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                arb_to_write <= 1'b0;
    else if (w_want && r_want) arb_to_write <= !arb_to_write;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi_req_i.aw_valid && aw_ready) begin
            w_id    <= axi_req_i.aw_id;
            w_addr  <= axi_req_i.aw_addr;
            w_len   <= axi_req_i.aw_len;
            w_size  <= axi_req_i.aw_size;
            w_burst <= axi_req_i.aw_burst;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_gnt) begin
            w_addr <= w_next;
            w_beat <= w_beat + 8'd1;
            if (w_beat_err || (axi_req_i.w_last != (w_beat == w_len))) w_err <= 1'b1;
            if (axi_req_i.w_last) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_req_i.b_ready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // R_DATA spends its first cycle capturing the memory output into r_data_q,
  // then holds it with r_valid until the master accepts the beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= R_IDLE;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi_req_i.ar_valid && ar_ready) begin
            r_id    <= axi_req_i.ar_id;
            r_addr  <= axi_req_i.ar_addr;
            r_len   <= axi_req_i.ar_len;
            r_size  <= axi_req_i.ar_size;
            r_burst <= axi_req_i.ar_burst;
            r_beat  <= '0;
            r_state <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          if (r_gnt) begin
            r_err_q <= r_beat_err;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (!r_valid_q) begin
            r_valid_q <= 1'b1;
            r_data_q  <= r_err_q ? '0 : mem_rdata_i;
          end else if (axi_req_i.r_ready) begin
            r_valid_q <= 1'b0;
            r_addr    <= r_next;
            r_beat    <= r_beat + 8'd1;
            r_state   <= (r_beat == r_len) ? R_IDLE : R_ISSUE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign w_do        = w_gnt && !w_beat_err;
  assign r_do        = r_gnt && !r_beat_err;
  assign mem_req_o   = w_do || r_do;
  assign mem_we_o    = w_do;
  assign mem_addr_o  = w_gnt ? w_addr[OffW +: MemAw] : r_addr[OffW +: MemAw];
  assign mem_wdata_o = axi_req_i.w_data;
  assign mem_be_o    = w_do ? axi_req_i.w_strb : '0;

  always_comb begin
    rsp          = '0;
    rsp.aw_ready = aw_ready;
    rsp.w_ready  = w_gnt;
    rsp.ar_ready = ar_ready;
    rsp.b_valid  = (w_state == W_RESP);
    rsp.b_id     = w_id;
    rsp.b_resp   = w_err ? RESP_SLVERR : RESP_OKAY;
    rsp.r_valid  = r_valid_q;
    rsp.r_id     = r_id;
    rsp.r_data   = r_data_q;
    rsp.r_resp   = r_err_q ? RESP_SLVERR : RESP_OKAY;
    rsp.r_last   = (r_beat == r_len);
  end

  assign axi_rsp_o = rsp;

  assign dbg_o.w_state      = w_state;
  assign dbg_o.r_state      = r_state;
  assign dbg_o.arb_to_write = arb_to_write;
  assign dbg_o.stall        = stall;

endmodule

// File: tb/tb_dram_axi_responder.sv
// Directed bench for dram_axi_responder: bench-side memory, burst address model
// and expected queues checked every cycle by one monitor.
module tb_dram_axi_responder;
  import dram_resp_pkg::*;

  localparam int unsigned MemWords = 1024;

  logic clk = 1'b0;
  logic rst_i = 1'b1;

  axi_req_t       req;
  axi_rsp_t       rsp;
  logic           mem_req, mem_we;
  logic [9:0]     mem_addr;
  logic [63:0]    mem_wdata, mem_rdata;
  logic [7:0]     mem_be;
  dram_resp_dbg_t dbg;

  logic [7:0]  aw_id = '0, ar_id = '0, aw_len = '0, ar_len = '0;
  logic [31:0] aw_addr = '0, ar_addr = '0;
  logic [2:0]  aw_size = '0, ar_size = '0;
  logic [1:0]  aw_burst = '0, ar_burst = '0;
  logic        aw_valid = 0, w_valid = 0, w_last = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;

  always #5 clk = ~clk;

  always_comb begin
    req          = '0;
    req.aw_id    = aw_id;
    req.aw_addr  = aw_addr;
    req.aw_len   = aw_len;
    req.aw_size  = aw_size;
    req.aw_burst = aw_burst;
    req.aw_valid = aw_valid;
    req.w_data   = w_data;
    req.w_strb   = w_strb;
    req.w_last   = w_last;
    req.w_valid  = w_valid;
    req.b_ready  = b_ready;
    req.ar_id    = ar_id;
    req.ar_addr  = ar_addr;
    req.ar_len   = ar_len;
    req.ar_size  = ar_size;
    req.ar_burst = ar_burst;
    req.ar_valid = ar_valid;
    req.r_ready  = r_ready;
  end

  dram_axi_responder #(
    .DataWidth (64),
    .AddrWidth (32),
    .MemWords  (MemWords)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .axi_req_i   (req),
    .axi_rsp_o   (rsp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata),
    .dbg_o       (dbg)
  );

  // Bench-side memory: single port, read data valid the cycle after the strobe.
  logic [63:0] mem [MemWords];
  logic [63:0] model_mem [MemWords];

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++) if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int tests = 0;
  int failed = 0;

  logic [81:0] exp_wr_q[$];
  logic [9:0]  exp_rd_q[$];
  logic [74:0] exp_r_q[$];
  logic [9:0]  exp_b_q[$];
  logic [9:0]  rd_log[$];
  logic [63:0] r_log[$];
  int          rd_count = 0;
  int          wr_count = 0;
  bit          prev_stalled = 0;
  logic [63:0] prev_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst, input int i);
    logic [31:0] step, bound, base;
    step  = 32'd1 << size;
    bound = (32'(len) + 32'd1) * step;
    if (burst == BURST_FIXED) return start;
    if (burst == BURST_WRAP) begin
      base = (start / bound) * bound;
      return base + ((start - base + 32'(i) * step) % bound);
    end
    if (i == 0) return start;
    return (start / step) * step + 32'(i) * step;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] size,
                                   input logic [7:0] len, input logic [1:0] burst);
    bit wrap_bad;
    wrap_bad = (burst == BURST_WRAP) && !(len == 1 || len == 3 || len == 7 || len == 15);
    return (burst == BURST_RSVD) || (size > 3'd3) || wrap_bad || (a >= 32'(MemWords * 8));
  endfunction

  function automatic logic ready_of(input int ch);
    case (ch)
      0:       return rsp.aw_ready;
      1:       return rsp.w_ready;
      2:       return rsp.b_valid;
      3:       return rsp.ar_ready;
      default: return rsp.r_valid;
    endcase
  endfunction

  // Waits for the channel condition (bounded), then steps past the transfer edge.
  task automatic wait_ready(input int ch, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (ready_of(ch)) break;
      n++;
      if (n > 200) begin
        tests++;
        failed++;
        $display("FAIL %s_timeout: got no handshake expected one within 200 cycles", name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [63:0] seed);
    bit any_err = 0;
    logic [31:0] a;
    logic [63:0] d;
    for (int i = 0; i <= int'(len); i++) begin
      a = model_addr(addr, size, len, burst, i);
      d = seed * 64'(i + 1);
      if (model_err(a, size, len, burst)) any_err = 1;
      else begin
        exp_wr_q.push_back({a[12:3], d, 8'hFF});
        model_mem[a[12:3]] = d;
      end
    end
    exp_b_q.push_back({id, any_err ? RESP_SLVERR : RESP_OKAY});
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1;
    wait_ready(0, "aw");
    aw_valid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = seed * 64'(i + 1); w_strb = 8'hFF; w_last = (i == int'(len)); w_valid = 1;
      wait_ready(1, "w");
    end
    w_valid = 0; w_last = 0; b_ready = 1;
    wait_ready(2, "b");
    b_ready = 0;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    logic [31:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = model_addr(addr, size, len, burst, i);
      if (model_err(a, size, len, burst)) begin
        exp_r_q.push_back({id, 64'h0, RESP_SLVERR, i == int'(len)});
      end else begin
        exp_rd_q.push_back(a[12:3]);
        exp_r_q.push_back({id, model_mem[a[12:3]], RESP_OKAY, i == int'(len)});
      end
    end
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1;
    wait_ready(3, "ar");
    ar_valid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        r_ready = 0;
        wait_ready(4, "r_stall");
        repeat (4) @(posedge clk);
        #1;
      end
      r_ready = 1;
      wait_ready(4, "r");
    end
    r_ready = 0;
  endtask

  // Monitor: every memory access and every B/R transfer is set against the model.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_stalled = 0;
    end else begin
      if (mem_req) begin
        if (mem_we) begin
          wr_count++;
          if (exp_wr_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL mem_wr_unexpected: got write to %0h expected none", mem_addr);
          end else check("mem_wr", 128'({mem_addr, mem_wdata, mem_be}), 128'(exp_wr_q.pop_front()));
        end else begin
          rd_count++;
          rd_log.push_back(mem_addr);
          if (exp_rd_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL mem_rd_unexpected: got read of %0h expected none", mem_addr);
          end else check("mem_rd", 128'(mem_addr), 128'(exp_rd_q.pop_front()));
        end
      end
      if (prev_stalled) begin
        check("r_valid_hold", 128'(rsp.r_valid), 128'(1));
        check("r_data_hold", 128'(rsp.r_data), 128'(prev_data));
      end
      prev_stalled = rsp.r_valid && !r_ready;
      prev_data    = rsp.r_data;
      if (rsp.r_valid && r_ready) begin
        r_log.push_back(rsp.r_data);
        check("r_user", 128'(rsp.r_user), 128'(0));
        if (exp_r_q.size() == 0) begin
          tests++; failed++;
          $display("FAIL r_unexpected: got beat %0h expected none", rsp.r_data);
        end else check("r_beat", 128'({rsp.r_id, rsp.r_data, rsp.r_resp, rsp.r_last}),
                       128'(exp_r_q.pop_front()));
      end
      if (rsp.b_valid && b_ready) begin
        check("b_user", 128'(rsp.b_user), 128'(0));
        if (exp_b_q.size() == 0) begin
          tests++; failed++;
          $display("FAIL b_unexpected: got id %0h expected none", rsp.b_id);
        end else check("b_resp", 128'({rsp.b_id, rsp.b_resp}), 128'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    int c0;
    logic [9:0]  lit_a [4];
    logic [63:0] lit_d [4];
    for (int i = 0; i < int'(MemWords); i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    mem_rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_aw_ready", 128'(rsp.aw_ready), 128'(0));
    check("rst_ar_ready", 128'(rsp.ar_ready), 128'(0));
    check("rst_w_ready", 128'(rsp.w_ready), 128'(0));
    check("rst_b_valid", 128'(rsp.b_valid), 128'(0));
    check("rst_r_valid", 128'(rsp.r_valid), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_fsm_idle", 128'({dbg.w_state, dbg.r_state}), 128'({W_IDLE, R_IDLE}));
    check("rst_arb_read", 128'(dbg.arb_to_write), 128'(0));
    @(posedge clk); #1; rst_i = 0;
    @(posedge clk); @(negedge clk);
    check("idle_aw_ready", 128'(rsp.aw_ready), 128'(1));
    check("idle_ar_ready", 128'(rsp.ar_ready), 128'(1));
    @(posedge clk); #1;

    // INCR write then read of four beats at 0x100
    c0 = wr_count;
    axi_write(8'h01, 32'h100, 8'd3, 3'd3, BURST_INCR, 64'h11);
    check("incr_wr_count", 128'(wr_count - c0), 128'(4));
    check("incr_mem_0x20", 128'(mem[10'h20]), 128'(64'h11));
    check("incr_mem_0x23", 128'(mem[10'h23]), 128'(64'h44));
    rd_log.delete(); r_log.delete();
    axi_read(8'h02, 32'h100, 8'd3, 3'd3, BURST_INCR, -1);
    lit_a = '{10'h20, 10'h21, 10'h22, 10'h23};
    lit_d = '{64'h11, 64'h22, 64'h33, 64'h44};
    check("incr_rd_n", 128'(rd_log.size()), 128'(4));
    check("incr_r_n", 128'(r_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < rd_log.size() && i < r_log.size(); i++) begin
      check("incr_rd_addr", 128'(rd_log[i]), 128'(lit_a[i]));
      check("incr_r_data", 128'(r_log[i]), 128'(lit_d[i]));
    end

    // WRAP read starting mid-window
    rd_log.delete(); r_log.delete();
    axi_read(8'h03, 32'h118, 8'd3, 3'd3, BURST_WRAP, -1);
    lit_a = '{10'h23, 10'h20, 10'h21, 10'h22};
    lit_d = '{64'h44, 64'h11, 64'h22, 64'h33};
    check("wrap_rd_n", 128'(rd_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < rd_log.size() && i < r_log.size(); i++) begin
      check("wrap_rd_addr", 128'(rd_log[i]), 128'(lit_a[i]));
      check("wrap_r_data", 128'(r_log[i]), 128'(lit_d[i]));
    end

    // Concurrent eight-beat write and read contend for the port
    c0 = rd_count + wr_count;
    fork
      axi_write(8'h04, 32'h400, 8'd7, 3'd3, BURST_INCR, 64'h1000);
      axi_read(8'h05, 32'h100, 8'd7, 3'd3, BURST_INCR, -1);
    join
    check("concurrent_accesses", 128'(rd_count + wr_count - c0), 128'(16));

    // Out-of-range read and reserved-burst write
    c0 = rd_count; r_log.delete();
    axi_read(8'h09, 32'(MemWords * 8), 8'd0, 3'd3, BURST_INCR, -1);
    check("oor_rd_count", 128'(rd_count - c0), 128'(0));
    check("oor_r_data", 128'(r_log.size() == 1 ? r_log[0] : 64'hdead), 128'(64'h0));
    c0 = wr_count;
    axi_write(8'h0A, 32'h100, 8'd1, 3'd3, BURST_RSVD, 64'h77);
    check("rsvd_wr_count", 128'(wr_count - c0), 128'(0));

    // r_ready held low for five cycles on beat 1
    c0 = rd_count;
    axi_read(8'h07, 32'h100, 8'd3, 3'd3, BURST_INCR, 1);
    check("stall_rd_count", 128'(rd_count - c0), 128'(4));

    // Reset during beat 2 of an eight-beat write
    exp_wr_q.push_back({10'h40, 64'hA0, 8'hFF}); model_mem[10'h40] = 64'hA0;
    exp_wr_q.push_back({10'h41, 64'hA1, 8'hFF}); model_mem[10'h41] = 64'hA1;
    aw_id = 8'h0B; aw_addr = 32'h200; aw_len = 8'd7; aw_size = 3'd3; aw_burst = BURST_INCR; aw_valid = 1;
    wait_ready(0, "aw_rst");
    aw_valid = 0;
    for (int i = 0; i < 2; i++) begin
      w_data = 64'hA0 + 64'(i); w_strb = 8'hFF; w_last = 0; w_valid = 1;
      wait_ready(1, "w_rst");
    end
    w_data = 64'hA2; rst_i = 1;
    @(negedge clk);
    check("midrst_b_valid", 128'(rsp.b_valid), 128'(0));
    check("midrst_r_valid", 128'(rsp.r_valid), 128'(0));
    check("midrst_w_ready", 128'(rsp.w_ready), 128'(0));
    check("midrst_mem_req", 128'(mem_req), 128'(0));
    w_valid = 0;
    @(posedge clk); #1; rst_i = 0;
    @(posedge clk); @(negedge clk);
    check("postrst_aw_ready", 128'(rsp.aw_ready), 128'(1));
    @(posedge clk); #1;
    axi_write(8'h0C, 32'h300, 8'd0, 3'd3, BURST_INCR, 64'h55);
    r_log.delete();
    axi_read(8'h0D, 32'h200, 8'd2, 3'd3, BURST_INCR, -1);
    check("midrst_beat2_absent", 128'(r_log.size() == 3 ? r_log[2] : 64'hdead), 128'(64'h0));

    repeat (5) @(posedge clk);
    check("left_exp_wr", 128'(exp_wr_q.size()), 128'(0));
    check("left_exp_rd", 128'(exp_rd_q.size()), 128'(0));
    check("left_exp_r", 128'(exp_r_q.size()), 128'(0));
    check("left_exp_b", 128'(exp_b_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dram_axi_responder.md
Name: dram_axi_responder

Overview:
- AXI4 subordinate that terminates the DRAM-side AXI port in simulation and emulation builds, taking the place of the vendor memory controller.
- Accepts requests on the DRAM AXI clock domain after the CDC and spill stages, and serves bursts from a single-port, word-addressed memory with 1-cycle read latency.
- Echoes full AXI IDs, so no ID narrowing is needed downstream of it.

Parameters:
- DataWidth, 64, AXI data width in bits (power of two, 32..512).
- AddrWidth, 32, AXI address width in bits.
- MemWords, 2**20, number of memory words; valid byte range is [0, MemWords*DataWidth/8).
- axi_req_t, logic, AXI request struct type.
- axi_rsp_t, logic, AXI response struct type.
- StallSeed, 16'hACE1, LFSR seed; used only when DRAM_RESP_STALL_EN is defined.

Ports:
- clk_i  in  1  DRAM AXI clock.
- rst_i  in  1  asynchronous, active-high reset.
- axi_req_i  in  struct  AXI request (AW/W/AR channels, b_ready, r_ready).
- axi_rsp_o  out  struct  AXI response (B/R channels, aw/w/ar ready).
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  $clog2(MemWords)  word address.
- mem_wdata_o  out  DataWidth  write data.
- mem_be_o  out  DataWidth/8  byte enables (copy of wstrb).
- mem_rdata_i  in  DataWidth  read data, valid the cycle after a read strobe.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: all readys 0, b_valid 0, r_valid 0, mem_req_o 0, both FSMs in IDLE, arbitration flag points to read.
- Once out of reset, IDLE drives aw_ready / ar_ready to 1.
- Outstanding limit: one read burst and one write burst at a time, fully independent of each other.
- Write FSM:
  - W_IDLE: on aw handshake, latch id/addr/len/size/burst; go to W_DATA.
  - W_DATA: w_ready=1 only in a cycle where this FSM owns the memory port. Each beat issues a write (mem_we_o=1, mem_be_o=wstrb) and advances the address. On the beat with wlast, go to W_RESP.
  - wlast not matching len: error flag set; resp=SLVERR.
  - W_RESP: b_valid=1, b.id=latched id; hold until b_ready; then W_IDLE.
- Read FSM:
  - R_IDLE: on ar handshake, latch fields; go to R_ISSUE.
  - R_ISSUE: when granted, mem_req_o=1, we=0; go to R_DATA.
  - R_DATA: capture mem_rdata_i into the R register; r_valid=1; r.last=1 when the beat counter equals len.
  - On r handshake: if last, go to R_IDLE; else go to R_ISSUE.
  - r.data stays stable while r_valid && !r_ready.
- Arbitration:
  - Single memory port. If both FSMs want it in the same cycle, the grant alternates, and the arbitration flag toggles after each contended grant.
  - Uncontended requests are granted immediately.
- Address generation (byte address, step = 1<<size):
  - FIXED: address unchanged.
  - INCR: address aligned down to size, then step added.
  - WRAP: wrap boundary = (len+1)*step; address wraps at the boundary. WRAP with len not in {1,3,7,15} → SLVERR.
  - mem_addr_o = addr >> $clog2(DataWidth/8).
- Errors:
  - burst==2'b11, or any beat with address >= MemWords*DataWidth/8: beat suppressed (no mem access), response SLVERR.
  - Reads return data 0 with SLVERR on that beat only.
  - Writes report SLVERR in B if any beat errored.
  - size > $clog2(DataWidth/8) → SLVERR for the whole burst.
- user fields return 0.
- Reset mid-burst: FSMs return to IDLE at once and the partial burst is abandoned; any memory write already issued stays in memory.

Optional Feature:
- DRAM_RESP_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with StallSeed at reset, advances every cycle.
  - When LFSR bit0=1, aw_ready, ar_ready and w_ready are forced to 0 and R_ISSUE does not request the port.
  - Used to exercise backpressure; results stay deterministic for a given seed.
- Undefined: no LFSR is instantiated and no stalls are inserted.

Decomposition:
- Package dram_resp_pkg holds:
  - burst/resp encodings (BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR);
  - the write and read FSM state enums;
  - function next_addr(addr, size, len, burst).
- Sub-module dram_resp_addr_gen: a combinational wrapper around next_addr that also flags errors. It is instantiated once per FSM.

Test Plan:
- INCR write of 4 beats, size=3, addr 0x100, data 0x11..0x44, then INCR read of 4 beats → B OKAY; R returns 0x11,0x22,0x33,0x44 with last on beat 4; mem addresses 0x20..0x23.
- WRAP read, len=3, size=3, addr 0x118 → word addresses 0x23,0x20,0x21,0x22.
- Concurrent 8-beat write and 8-beat read → grants alternate; no beat lost; total 16 memory accesses.
- Read at addr MemWords*8 (DataWidth=64) → SLVERR, data 0, no mem_req_o; write with burst=2'b11 → B SLVERR, no mem_we_o.
- r_ready low for 5 cycles mid-burst → r.data and r_valid stable; no extra mem_req_o.
- rst_i asserted during beat 2 of an 8-beat write → all valids 0 the next cycle; a new AW is accepted after release.
